// File: rtl/ps2_keycode_fifo.sv
// ps2_keycode_fifo
// Buffers scancodes from the PS/2 receiver and presents them one at a time to
// the host through an XT-style irq / clear_keycode handshake. The receiver is
// acknowledged as soon as a code is latched, so codes typed while the BIOS ISR
// is busy are queued. After a FIFO overflow an overrun code is injected into
// the stream once space is available again.
//
// Data flow:
//   receiver --(capture FSM)--> FIFO (DEPTH entries) --(pop)--> keycode/irq
// The output register sits outside the FIFO, so fifo_count does not include
// the code currently presented to the host.

module ps2_keycode_fifo #(
  parameter int          DEPTH        = 16,
  parameter int          DEPTH_LOG2   = 4,
  parameter int          CLEAR_PULSE  = 4,
  parameter logic [7:0]  OVERRUN_CODE = 8'hFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  kb_irq,
  input  logic [7:0]            kb_keycode,
  output logic                  kb_clear,
  input  logic                  clear_keycode,
  output logic [7:0]            keycode,
  output logic                  irq,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int                    CW         = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);
  localparam logic [3:0]            PULSE_LAST = 4'(CLEAR_PULSE - 1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1);

  // Receiver-side capture handshake: IDLE waits for a code, ACK holds
  // kb_clear for at least CLEAR_PULSE clocks and until kb_irq drops.
  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_ACK  = 1'b1
  } cap_state_t;

  cap_state_t              r_state;
  cap_state_t              w_state_next;
  logic [3:0]              r_pulse_cnt;
  logic [3:0]              w_pulse_cnt_next;
  logic                    r_kb_clear;
  logic                    w_kb_clear_next;
  logic                    w_capture;

  // FIFO storage and bookkeeping
  logic [7:0]              r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wptr;
  logic [DEPTH_LOG2-1:0]   r_rptr;
  logic [CW-1:0]           r_count;
  logic                    r_overflow;

  // Host-side presentation
  logic [7:0]              r_keycode;
  logic                    r_irq;
  logic                    r_clr_prev;

  // Datapath decisions
  logic                    w_full;
  logic                    w_empty;
  logic                    w_cap_push;
  logic                    w_inject;
  logic                    w_push;
  logic [7:0]              w_push_data;
  logic                    w_pop;
  logic                    w_clr_rise;

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------

  // Capture FSM state, pulse counter and kb_clear register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= CAP_IDLE;
      r_pulse_cnt <= '0;
      r_kb_clear  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pulse_cnt <= w_pulse_cnt_next;
      r_kb_clear  <= w_kb_clear_next;
    end
  end

  // Capture FSM next-state: latch a code in IDLE, stretch kb_clear in ACK.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next     = r_state;
    w_pulse_cnt_next = r_pulse_cnt;
    w_kb_clear_next  = r_kb_clear;
    w_capture        = 1'b0;

    case (r_state)
      CAP_IDLE: begin
        w_kb_clear_next = 1'b0;
        if (kb_irq) begin
          w_capture        = 1'b1;
          w_state_next     = CAP_ACK;
          w_pulse_cnt_next = '0;
          w_kb_clear_next  = 1'b1;
        end
      end
      CAP_ACK: begin
        w_kb_clear_next = 1'b1;
        if ((r_pulse_cnt >= PULSE_LAST) && !kb_irq) begin
          w_state_next     = CAP_IDLE;
          w_pulse_cnt_next = '0;
          w_kb_clear_next  = 1'b0;
        end else if (r_pulse_cnt != 4'hF) begin
          // Saturate so a receiver stuck high cannot wrap the counter.
          w_pulse_cnt_next = r_pulse_cnt + 4'd1;
        end
      end
      default: begin
        w_state_next    = CAP_IDLE;
        w_kb_clear_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Push / pop decisions
  // ---------------------------------------------------------------------------

  // Decide what enters and leaves the FIFO this cycle.
  always_comb begin
    w_full      = (r_count == FULL_COUNT);
    w_empty     = (r_count == '0);
    // A capture is stored only if there is room and no overrun is pending.
    w_cap_push  = w_capture && !w_full && !r_overflow;
    // The overrun marker goes in on the first cycle with room and no
    // competing capture push; a capture on that edge is dropped because
    // overflow is still set.
    w_inject    = r_overflow && !w_full && !w_cap_push;
    w_push      = w_cap_push || w_inject;
    w_push_data = w_inject ? OVERRUN_CODE : kb_keycode;
    // Present a new code only when the output register is free and the host
    // is not holding its acknowledge high. No bypass: the code must already
    // be stored in the FIFO.
    w_pop       = !r_irq && !clear_keycode && !w_empty;
    w_clr_rise  = clear_keycode && !r_clr_prev;
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------

  // FIFO data array write port.
  // NOTE: the storage array is not reset; stale entries are unreachable
  // because the pointers and count are reset, and leaving it out of reset
  // lets it map to plain RAM.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

  // Read/write pointers wrap modulo DEPTH; count tracks net occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Overrun flag: set by a capture that finds the FIFO full, cleared when
  // the overrun code is injected.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_capture && w_full) begin
      r_overflow <= 1'b1;
    end else if (w_inject) begin
      r_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Host presentation
  // ---------------------------------------------------------------------------

  // Output register: load on pop, drop irq on a rising host acknowledge.
  // keycode keeps its value after the acknowledge until the next pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_keycode <= 8'h00;
      r_irq     <= 1'b0;
    end else if (w_pop) begin
      r_keycode <= r_mem[r_rptr];
      r_irq     <= 1'b1;
    end else if (w_clr_rise) begin
      r_irq     <= 1'b0;
    end
  end

  // Previous acknowledge level; resets high so an acknowledge already held
  // high through reset is not mistaken for a new edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clr_prev <= 1'b1;
    end else begin
      r_clr_prev <= clear_keycode;
    end
  end

  assign kb_clear   = r_kb_clear;
  assign keycode    = r_keycode;
  assign irq        = r_irq;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

  // Occupancy must stay within the FIFO depth.
  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    r_count <= FULL_COUNT);

endmodule

// File: tb/tb_ps2_keycode_fifo.sv
// Testbench for ps2_keycode_fifo: directed scenarios followed by randomized
// receiver/host traffic, every cycle compared against a queue-based model.

module tb_ps2_keycode_fifo;

  localparam int         DEPTH        = 16;
  localparam int         DEPTH_LOG2   = 4;
  localparam int         CLEAR_PULSE  = 4;
  localparam logic [7:0] OVERRUN_CODE = 8'hFF;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                kb_irq = 1'b0;
  logic [7:0]          kb_keycode = 8'h00;
  logic                kb_clear;
  logic                clear_keycode = 1'b0;
  logic [7:0]          keycode;
  logic                irq;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                overflow;

  int n_vectors    = 0;
  int n_miscompares = 0;

  ps2_keycode_fifo #(
    .DEPTH        (DEPTH),
    .DEPTH_LOG2   (DEPTH_LOG2),
    .CLEAR_PULSE  (CLEAR_PULSE),
    .OVERRUN_CODE (OVERRUN_CODE)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .kb_irq        (kb_irq),
    .kb_keycode    (kb_keycode),
    .kb_clear      (kb_clear),
    .clear_keycode (clear_keycode),
    .keycode       (keycode),
    .irq           (irq),
    .fifo_count    (fifo_count),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Reference model: a byte queue plus the handshake flags
  // ---------------------------------------------------------------------------
  logic [7:0] m_q [$];
  logic [7:0] m_key;
  bit         m_valid;
  bit         m_ovf;
  bit         m_ack;
  int         m_cnt;
  bit         m_kbclr;
  bit         m_clr_prev;

  task automatic model_edge();
    bit cap, pop, rise, old_ovf;
    int n;
    if (reset) begin
      m_q.delete();
      m_key      = 8'h00;
      m_valid    = 0;
      m_ovf      = 0;
      m_ack      = 0;
      m_cnt      = 0;
      m_kbclr    = 0;
      m_clr_prev = 1;
    end else begin
      n       = m_q.size();
      old_ovf = m_ovf;
      cap     = !m_ack && kb_irq;
      pop     = !m_valid && !clear_keycode && (n > 0);
      rise    = clear_keycode && !m_clr_prev;
      if (pop) begin
        m_key   = m_q.pop_front();
        m_valid = 1;
      end else if (rise) begin
        m_valid = 0;
      end
      if (cap && !old_ovf) begin
        if (n == DEPTH) m_ovf = 1;
        else            m_q.push_back(kb_keycode);
      end
      if (old_ovf && n < DEPTH) begin
        m_q.push_back(OVERRUN_CODE);
        m_ovf = 0;
      end
      if (cap) begin
        m_ack   = 1;
        m_cnt   = 0;
        m_kbclr = 1;
      end else if (m_ack) begin
        if (m_cnt >= CLEAR_PULSE - 1 && !kb_irq) begin
          m_ack   = 0;
          m_kbclr = 0;
        end else begin
          m_cnt++;
        end
      end
      m_clr_prev = clear_keycode;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking and clocking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // One clock: model advances on the edge, outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check("cyc_kb_clear",   kb_clear,   m_kbclr);
    check("cyc_irq",        irq,        m_valid);
    check("cyc_keycode",    keycode,    m_key);
    check("cyc_fifo_count", fifo_count, m_q.size());
    check("cyc_overflow",   overflow,   m_ovf);
  endtask

  // Receiver delivering one code: raise, wait for kb_clear, drop, wait release.
  task automatic send_code(input logic [7:0] c);
    int n;
    kb_irq     = 1'b1;
    kb_keycode = c;
    n = 0;
    do begin tick(); n++; end while (!kb_clear && n < 20);
    check("send_ack_seen", kb_clear, 1);
    kb_irq = 1'b0;
    n = 0;
    do begin tick(); n++; end while (kb_clear && n < 20);
    check("send_released", kb_clear, 0);
  endtask

  // Host acknowledge: PB7 high for one clock then low for one clock.
  task automatic ack();
    clear_keycode = 1'b1;
    tick();
    clear_keycode = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] exp_q [$];
    int slow;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_kb_clear", kb_clear, 0);
    check("rst_keycode",  keycode,  8'h00);
    check("rst_irq",      irq,      0);
    check("rst_count",    fifo_count, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    tick();

    // 1. Single code
    kb_irq = 1'b1;
    kb_keycode = 8'h1C;
    tick();                                   // edge 0
    check("t1_e0_kb_clear", kb_clear, 1);
    check("t1_e0_irq",      irq, 0);
    check("t1_e0_count",    fifo_count, 1);
    tick();                                   // edge 1
    check("t1_e1_irq",      irq, 1);
    check("t1_e1_keycode",  keycode, 8'h1C);
    check("t1_e1_kb_clear", kb_clear, 1);
    kb_irq = 1'b0;
    tick();                                   // edge 2
    check("t1_e2_kb_clear", kb_clear, 1);
    tick();                                   // edge 3
    check("t1_e3_kb_clear", kb_clear, 1);
    tick();                                   // edge 4
    check("t1_e4_kb_clear", kb_clear, 0);
    repeat (5) tick();                        // edges 5..9
    clear_keycode = 1'b1;
    tick();                                   // edge 10
    check("t1_e10_irq",     irq, 0);
    check("t1_e10_keycode", keycode, 8'h1C);
    clear_keycode = 1'b0;
    tick();
    check("t1_idle_irq",    irq, 0);

    // 2. Burst ordering
    send_code(8'h2A);
    send_code(8'h1E);
    send_code(8'hAA);
    check("t2_keycode", keycode, 8'h2A);
    check("t2_count",   fifo_count, 2);
    ack();
    check("t2_a1_keycode", keycode, 8'h1E);
    check("t2_a1_irq",     irq, 1);
    ack();
    check("t2_a2_keycode", keycode, 8'hAA);
    check("t2_a2_count",   fifo_count, 0);
    ack();
    check("t2_a3_irq",     irq, 0);
    check("t2_a3_count",   fifo_count, 0);
    check("t2_a3_keycode", keycode, 8'hAA);

    // 3. Overflow and overrun injection
    for (int v = 1; v <= 18; v++) send_code(8'(v));
    check("t3_keycode",  keycode, 8'h01);
    check("t3_count",    fifo_count, DEPTH);
    check("t3_overflow", overflow, 1);
    send_code(8'h13);
    check("t3_13_count",    fifo_count, DEPTH);
    check("t3_13_overflow", overflow, 1);
    ack();
    check("t3_pop_keycode",  keycode, 8'h02);
    check("t3_pop_count",    fifo_count, DEPTH - 1);
    tick();
    check("t3_inj_count",    fifo_count, DEPTH);
    check("t3_inj_overflow", overflow, 0);
    ack();
    check("t3_pop2_keycode", keycode, 8'h03);
    send_code(8'h14);
    check("t3_14_count",     fifo_count, DEPTH);
    check("t3_14_overflow",  overflow, 0);
    for (int v = 4; v <= 17; v++) exp_q.push_back(8'(v));
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h14);
    foreach (exp_q[i]) begin
      ack();
      check("t3_drain_keycode", keycode, exp_q[i]);
    end
    ack();
    check("t3_drained_irq",   irq, 0);
    check("t3_drained_count", fifo_count, 0);

    // 4. Simultaneous push and pop
    clear_keycode = 1'b1;
    tick();
    send_code(8'h31);
    send_code(8'h32);
    send_code(8'h33);
    check("t4_pre_count", fifo_count, 3);
    check("t4_pre_irq",   irq, 0);
    kb_irq        = 1'b1;
    kb_keycode    = 8'h34;
    clear_keycode = 1'b0;
    tick();
    check("t4_count",   fifo_count, 3);
    check("t4_irq",     irq, 1);
    check("t4_keycode", keycode, 8'h31);
    kb_irq = 1'b0;
    for (int n = 0; n < 20 && kb_clear; n++) tick();
    check("t4_released", kb_clear, 0);
    ack();
    check("t4_k2", keycode, 8'h32);
    ack();
    check("t4_k3", keycode, 8'h33);
    ack();
    check("t4_k4", keycode, 8'h34);
    check("t4_end_count", fifo_count, 0);

    // 5. Stuck kb_irq
    reset = 1'b1;
    tick();
    reset = 1'b0;
    kb_irq     = 1'b1;
    kb_keycode = 8'h3B;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t5_kb_clear_held", kb_clear, 1);
    end
    kb_irq = 1'b0;
    tick();
    check("t5_kb_clear_low", kb_clear, 0);
    check("t5_count",        fifo_count, 0);
    check("t5_irq",          irq, 1);
    check("t5_keycode",      keycode, 8'h3B);

    // 6. Reset mid-burst
    for (int v = 8'h41; v <= 8'h44; v++) send_code(8'(v));
    kb_irq     = 1'b1;
    kb_keycode = 8'h45;
    tick();
    check("t6_pre_count",    fifo_count, 5);
    check("t6_pre_kb_clear", kb_clear, 1);
    check("t6_pre_irq",      irq, 1);
    kb_irq = 1'b0;
    reset  = 1'b1;
    tick();
    check("t6_rst_kb_clear", kb_clear, 0);
    check("t6_rst_keycode",  keycode, 8'h00);
    check("t6_rst_irq",      irq, 0);
    check("t6_rst_count",    fifo_count, 0);
    check("t6_rst_overflow", overflow, 0);
    reset = 1'b0;
    repeat (3) tick();
    check("t6_quiet_count", fifo_count, 0);
    check("t6_quiet_irq",   irq, 0);
    send_code(8'h1F);
    check("t6_new_keycode", keycode, 8'h1F);
    check("t6_new_irq",     irq, 1);

    // Randomized receiver/host traffic with slow-host phases and rare resets
    slow = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 400 == 0) slow = int'($urandom_range(0, 2));
      reset = ($urandom_range(0, 599) == 0);
      if (!kb_irq) begin
        if (!kb_clear && $urandom_range(0, 2) == 0) begin
          kb_irq     = 1'b1;
          kb_keycode = 8'($urandom);
        end
      end else if (kb_clear && $urandom_range(0, 1) == 0) begin
        kb_irq = 1'b0;
      end
      if (clear_keycode) begin
        if ($urandom_range(0, 1) == 0) clear_keycode = 1'b0;
      end else if (irq && $urandom_range(0, (slow == 0) ? 60 : 3) == 0) begin
        clear_keycode = 1'b1;
      end
      tick();
    end

    reset         = 1'b0;
    kb_irq        = 1'b0;
    clear_keycode = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  // Run-time bound in case the design stops responding.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_keycode_fifo.md
Name: ps2_keycode_fifo

Overview:
- Buffering stage between the PS/2 keyboard receiver and the chipset's 8255 port A / 8259 IR1.
- Accepts each scancode the receiver latches and acknowledges the receiver immediately, so fast typing is not lost while the BIOS ISR runs.
- Presents codes one at a time to the host with an XT-style irq/clear handshake: irq high, host reads port A, host pulses PB7.
- Injects an overrun code after a FIFO overflow.

Parameters:
- DEPTH, 16: FIFO entries, power of two, excluding the output register.
- DEPTH_LOG2, 4: log2(DEPTH).
- CLEAR_PULSE, 4: minimum clocks kb_clear is held high per accepted code, range 1..15.
- OVERRUN_CODE, 8'hFF: code injected after overflow.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- kb_irq  in  1  receiver "keycode valid" level.
- kb_keycode  in  8  receiver keycode, valid while kb_irq=1.
- kb_clear  out  1  to receiver clear_keycode; registered.
- clear_keycode  in  1  host acknowledge (8255 PB7), level.
- keycode  out  8  to 8255 port A input; registered.
- irq  out  1  to 8259 IR1; registered, level.
- fifo_count  out  DEPTH_LOG2+1  entries held, excluding the output register.
- overflow  out  1  overrun pending flag.

Behaviour:
- Reset (sync, active-high). kb_clear=0, keycode=8'h00, irq=0, fifo_count=0, overflow=0, capture FSM=IDLE, pointers=0. A reset mid-operation discards all stored codes. If kb_irq is still high after reset, it is captured as a fresh code.
- Capture FSM, IDLE:
  - kb_irq=1 sampled at edge N: push kb_keycode at edge N, unless full or overflow=1 (see below).
  - Go to ACK with pulse counter=0. kb_clear=1 from edge N.
- Capture FSM, ACK:
  - kb_clear=1; counter increments each clock.
  - When counter >= CLEAR_PULSE-1 and kb_irq=0: kb_clear=0, go to IDLE.
  - If kb_irq is still high, stay in ACK with kb_clear held. No second push.
- Full:
  - A capture when fifo_count=DEPTH discards the code and sets overflow=1. The receiver is still acknowledged.
  - While overflow=1, every captured code is discarded.
- Overrun injection:
  - Occurs when overflow=1, fifo_count<DEPTH, and no capture push happens this cycle.
  - Push OVERRUN_CODE and clear overflow at the same edge.
  - A capture arriving that same edge is discarded.
- Presentation:
  - Condition: out_valid=0, clear_keycode=0, FIFO non-empty.
  - Action: pop the head into keycode, irq=1, out_valid=1 at that edge.
  - Earliest irq: one edge after the push edge. No bypass path.
- Host acknowledge:
  - Rising edge of clear_keycode (registered previous value) at edge M: irq=0, out_valid=0 at edge M.
  - keycode holds its last value until the next pop.
  - The next code is presented no earlier than one edge after clear_keycode returns to 0.
  - clear_keycode high during reset is not treated as an edge after reset. The previous-value register resets to 1.
- Simultaneous push and pop: both occur; fifo_count unchanged.
- Pointer arithmetic: read/write pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. fifo_count is updated as +1 (push), -1 (pop), or 0 (both or neither).
- fifo_count never exceeds DEPTH and never underflows. Pop is never attempted when empty.

Test Plan:
1. Single code. After reset, kb_irq=1 with 8'h1C at edge 0 and dropped at edge 2.
   - kb_clear high edges 0..3, low at edge 4.
   - irq=1 and keycode=8'h1C at edge 1.
   - clear_keycode pulsed high at edge 10: irq=0 at edge 10, keycode stays 8'h1C.
2. Burst ordering. Codes 8'h2A, 8'h1E, 8'hAA captured, no host ack.
   - keycode=8'h2A, fifo_count=2.
   - Each PB7 high/low pulse presents the next code in order, one edge after PB7 falls.
   - After the third ack: irq=0, fifo_count=0.
3. Overflow.
   - 18 codes (8'h01..8'h12), no ack: output holds 8'h01; FIFO holds 8'h02..8'h11, fifo_count=16; 8'h12 dropped; overflow=1.
   - Code 8'h13 while full: dropped.
   - One ack: 8'h02 popped; next idle cycle pushes 8'hFF behind 8'h11; overflow=0.
   - Code 8'h14 is then accepted after 8'hFF.
4. Simultaneous push/pop. fifo_count=3, capture and presentation pop on the same edge -> fifo_count stays 3; order preserved.
5. Stuck kb_irq. kb_irq held high 12 clocks with 8'h3B -> exactly one push; kb_clear high for all 12 clocks, low one edge after kb_irq falls.
6. Reset mid-burst. Reset with fifo_count=5, irq=1, kb_clear=1 -> next edge all outputs at reset values. kb_irq low: no spurious push. Pointers restart at 0; a new code 8'h1F is presented correctly.
